gpio_seq_tx: RTL and testbench

Output-side pattern transmitter for the user project area: drives a fixed, self-checking value sequence onto 18 user GPIO outputs (mprj_io[25:8]). The sequence is 1, 2, … LAST, all-ones, zero, with each value held for a programmable number of clocks. A chip-level monitor observes the pins and checks the sequence. The block owns both the output values and the active-low output enables for those pins.

---
 rtl/gpio_seq_tx.sv | 131 +++++++++++++
 tb/tb_gpio_seq_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gpio_seq_tx.sv
// Drives the GPIO sequence 1..LAST, all-ones, zero onto WIDTH pins, holding each value HOLD clocks.
// Define GPIO_SEQ_TX_LOOP_EN to restart at 1 after the zero step instead of stopping in DONE.
module gpio_seq_tx #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned HOLD  = 4,
    parameter int unsigned LAST  = 10
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             pause_i,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oeb,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_MAX = HW'(HOLD - 1);
    localparam logic [WIDTH-1:0] LAST_V   = WIDTH'(LAST);

    typedef enum logic [2:0] {StIdle, StCount, StOnes, StZero, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_val, w_val_d;
    logic [HW-1:0]    r_hold, w_hold_d;
    logic [WIDTH-1:0] r_out, w_out_d;
    logic [WIDTH-1:0] r_oeb, w_oeb_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;
    logic             w_step;
    logic [HW-1:0]    w_hold_adv;

    always_comb begin
        w_state_d  = r_state;
        w_val_d    = r_val;
        w_hold_d   = r_hold;
        w_out_d    = r_out;
        w_oeb_d    = r_oeb;
        w_busy_d   = r_busy;
        w_done_d   = r_done;
        w_step     = (r_hold == HOLD_MAX) && !pause_i;
        // Counter freezes while paused and wraps to 0 on each step.
        w_hold_adv = pause_i ? r_hold : (w_step ? '0 : r_hold + HW'(1));

        unique case (r_state)
            StIdle, StDone: begin
                if (start_i) begin
                    w_state_d = StCount;
                    w_val_d   = WIDTH'(1);
                    w_hold_d  = '0;
                    w_out_d   = WIDTH'(1);
                    w_oeb_d   = '0;
                    w_busy_d  = 1'b1;
                    w_done_d  = 1'b0;
                end
            end
            StCount: begin
                w_done_d = 1'b0;
                w_hold_d = w_hold_adv;
                if (w_step) begin
                    if (r_val < LAST_V) begin
                        w_val_d = r_val + WIDTH'(1);
                        w_out_d = r_val + WIDTH'(1);
                    end else begin
                        w_state_d = StOnes;
                        w_out_d   = '1;
                    end
                end
            end
            StOnes: begin
                w_done_d = 1'b0;
                w_hold_d = w_hold_adv;
                if (w_step) begin
                    w_state_d = StZero;
                    w_out_d   = '0;
                end
            end
            StZero: begin
                w_done_d = 1'b0;
                w_hold_d = w_hold_adv;
                if (w_step) begin
`ifdef GPIO_SEQ_TX_LOOP_EN
                    w_state_d = StCount;
                    w_val_d   = WIDTH'(1);
                    w_out_d   = WIDTH'(1);
                    w_done_d  = 1'b1;
`else
                    w_state_d = StDone;
                    w_out_d   = '0;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
`endif
                end
            end
            default: begin
                w_state_d = StIdle;
                w_out_d   = '0;
                w_oeb_d   = '1;
                w_busy_d  = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
            r_val   <= '0;
            r_hold  <= '0;
            r_out   <= '0;
            r_oeb   <= '1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_val   <= w_val_d;
            r_hold  <= w_hold_d;
            r_out   <= w_out_d;
            r_oeb   <= w_oeb_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    assign io_out = r_out;
    assign io_oeb = r_oeb;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_gpio_seq_tx.sv
// Scoreboard bench for gpio_seq_tx: a queue-based sequence model predicts the pins every cycle.
module tb_gpio_seq_tx;

`ifdef GPIO_SEQ_TX_LOOP_EN
    localparam int unsigned HOLD = 1;
    localparam int unsigned LAST = 2;
`else
    localparam int unsigned HOLD = 4;
    localparam int unsigned LAST = 10;
`endif
    localparam int unsigned WIDTH = 18;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic [WIDTH-1:0] oeb;
        logic             busy;
        logic             done;
    } exp_t;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic             start_i  = 1'b0;
    logic             pause_i  = 1'b0;
    logic [WIDTH-1:0] io_out;
    logic [WIDTH-1:0] io_oeb;
    logic             busy_o;
    logic             done_o;

    gpio_seq_tx #(
        .WIDTH(WIDTH),
        .HOLD (HOLD),
        .LAST (LAST)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .start_i (start_i),
        .pause_i (pause_i),
        .io_out  (io_out),
        .io_oeb  (io_oeb),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Model: the remaining displayed values, one entry per unpaused cycle.
    logic [WIDTH-1:0] m_seq[$];
    bit               m_active = 0;
    bit               m_fin    = 0;
    bit               m_pulse  = 0;
    exp_t             exp_q[$];
    int               checks   = 0;
    int               errors   = 0;
    int               cyc_n    = 0;

    task automatic fill_seq();
        m_seq.delete();
        for (int k = 1; k <= int'(LAST); k++)
            for (int h = 0; h < int'(HOLD); h++) m_seq.push_back(WIDTH'(k));
        for (int h = 0; h < int'(HOLD); h++) m_seq.push_back({WIDTH{1'b1}});
        for (int h = 0; h < int'(HOLD); h++) m_seq.push_back('0);
    endtask

    task automatic model_step(input bit rst, input bit st, input bit pa);
        exp_t e;
        if (rst) begin
            m_active = 0;
            m_fin    = 0;
            m_pulse  = 0;
            m_seq.delete();
        end else if (!m_active && st) begin
            fill_seq();
            m_active = 1;
            m_fin    = 0;
            m_pulse  = 0;
        end else if (m_active) begin
            m_pulse = 0;
            if (!pa) begin
                void'(m_seq.pop_front());
                if (m_seq.size() == 0) begin
`ifdef GPIO_SEQ_TX_LOOP_EN
                    fill_seq();
                    m_pulse = 1;
`else
                    m_active = 0;
                    m_fin    = 1;
`endif
                end
            end
        end
        if (m_active) e = '{out: m_seq[0], oeb: '0, busy: 1'b1, done: m_pulse};
        else if (m_fin) e = '{out: '0, oeb: '0, busy: 1'b0, done: 1'b1};
        else e = '{out: '0, oeb: {WIDTH{1'b1}}, busy: 1'b0, done: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit st, input bit pa);
        @(negedge wb_clk_i);
        wb_rst_i = rst;
        start_i  = st;
        pause_i  = pa;
        model_step(rst, st, pa);
    endtask

    // Monitor: outputs are valid every cycle, so compare one prediction per clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge wb_clk_i);
            #1;
            cyc_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (io_out !== e.out || io_oeb !== e.oeb || busy_o !== e.busy
                    || done_o !== e.done) begin
                    errors++;
                    $display("FAIL pins cycle %0d: got out=%h oeb=%h busy=%b done=%b, want out=%h oeb=%h busy=%b done=%b",
                             cyc_n, io_out, io_oeb, busy_o, done_o, e.out, e.oeb, e.busy,
                             e.done);
                end
            end
        end
    end

    initial begin
        repeat (3) cyc(1, 0, 0);
        repeat (8) cyc(0, 0, 0);
        // Clean run to completion.
        cyc(0, 1, 0);
        repeat (55) cyc(0, 0, 0);
        // Pause for 5 cycles while value 3 is shown.
        cyc(0, 1, 0);
        repeat (2 * HOLD + 1) cyc(0, 0, 0);
        repeat (5) cyc(0, 0, 1);
        repeat (50) cyc(0, 0, 0);
        // Start held high throughout: restart only from DONE.
        repeat (110) cyc(0, 1, 0);
        // Reset while value 6 is shown.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        repeat (5 * HOLD) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (10) cyc(0, 0, 0);
        // Reset and start together.
        cyc(1, 1, 0);
        repeat (3) cyc(0, 0, 0);
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 25);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
